// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO bus layout, UART frame constants and TX state encoding
// Optional parity state is used only when IO_UART_TX_PARITY_EN is defined.
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int IO_SEND_TOGGLE_BIT = 10;
    localparam int IO_DATA_MSB        = 7;
    localparam int IO_BUS_WIDTH       = 11;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_LINE_IDLE   = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers, shared by the UART TX and RX paths
// Head entry is presented combinationally on rdata whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage carries no reset; entries are only ever read between the pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - toggle-triggered byte queue and UART 8N1 serialiser on the core output bus
// Define IO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IO_BUS_WIDTH-1:0] io_output_bus,
    output logic                    tx,
    output logic                    busy,
    output logic                    fifo_full,
    output logic                    overflow
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t                 state, state_next;
    logic [BW-1:0]             baud_cnt, baud_next;
    logic [2:0]                bit_cnt, bit_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      tx_next;
    logic                      baud_done;

    logic                      prev_toggle;
    logic                      send;
    logic                      push;
    logic                      pop;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      unused_bus_bits;

`ifdef IO_UART_TX_PARITY_EN
    logic                      parity_bit, parity_next;
`endif

    assign unused_bus_bits = ^io_output_bus[IO_SEND_TOGGLE_BIT-1:IO_DATA_MSB+1];

    // Any level change on the toggle bit is one send request.
    assign send = io_output_bus[IO_SEND_TOGGLE_BIT] ^ prev_toggle;
    assign push = send && !fifo_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_toggle <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev_toggle <= io_output_bus[IO_SEND_TOGGLE_BIT];
            if (send && fifo_full) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (io_output_bus[IO_DATA_MSB:0]),
        .pop   (pop),
        .rdata (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= UART_LINE_IDLE;
`ifdef IO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
`ifdef IO_UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                    shift_next = fifo_data;
`ifdef IO_UART_TX_PARITY_EN
                    parity_next = even_parity(fifo_data);
`endif
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    state_next = ST_STOP;
                    baud_next  = '0;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                        shift_next = fifo_data;
`ifdef IO_UART_TX_PARITY_EN
                        parity_next = even_parity(fifo_data);
`endif
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // Line level is computed for the upcoming state and registered, so tx never glitches.
    always_comb begin
        tx_next = UART_LINE_IDLE;
        case (state_next)
            ST_IDLE:   tx_next = UART_LINE_IDLE;
            ST_START:  tx_next = UART_START_LEVEL;
            ST_DATA:   tx_next = shift_next[0];
`ifdef IO_UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_next;
`endif
            ST_STOP:   tx_next = UART_STOP_LEVEL;
            default:   tx_next = UART_LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed self-checking bench for io_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] bus   = '0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] burst [6];

    always #5 clock = ~clock;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_output_bus (bus),
        .tx            (tx),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tx !== 1'b0 && n < max);
    endtask

    // Entered on the first cycle of a start bit; returns on the last cycle of the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] data);
        check($sformatf("%s start", tag), tx, 1'b0);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clock);
            check($sformatf("%s d%0d", tag, b), tx, data[b]);
        end
`ifdef IO_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clock);
        check($sformatf("%s parity", tag), tx, ^data);
`endif
        repeat (CPB) @(negedge clock);
        check($sformatf("%s stop first", tag), tx, 1'b1);
        repeat (CPB - 1) @(negedge clock);
        check($sformatf("%s stop last", tag), tx, 1'b1);
    endtask

    initial begin
        int n;
        int lows;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        repeat (2) @(negedge clock);
        check("in reset", {28'd0, tx, busy, fifo_full, overflow}, 32'h8);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("idle c%0d", i), {28'd0, tx, busy, fifo_full, overflow}, 32'h8);
        end

        // single byte 0x55
        bus = 11'h455;
        wait_start(12, n);
        check("latency 55", n, 2);
        check_frame("f55", 8'h55);
        check("busy last stop", busy, 1'b1);
        @(negedge clock);
        check("busy after 55", busy, 1'b0);
        check("tx idle after 55", tx, 1'b1);

        // two consecutive toggles, back-to-back frames
        do_reset();
        bus = 11'h4A5;
        @(negedge clock);
        check("tx before A5", tx, 1'b1);
        check("busy queued A5", busy, 1'b1);
        bus = 11'h03C;
        wait_start(12, n);
        check("latency A5", n, 1);
        check_frame("fA5", 8'hA5);
        @(negedge clock);
        check_frame("f3C", 8'h3C);
        @(negedge clock);
        check("tx idle after 3C", tx, 1'b1);
        check("busy after 3C", busy, 1'b0);

        // six toggles into a depth-4 FIFO
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i == 5) begin
                        check("full before 6th", fifo_full, 1'b1);
                        check("ovf before 6th", overflow, 1'b0);
                    end
                    bus = {((i % 2) == 0) ? 1'b1 : 1'b0, 2'b00, burst[i]};
                    @(negedge clock);
                end
                check("ovf after 6th", overflow, 1'b1);
            end
            begin
                int m;
                wait_start(12, m);
                check("latency burst", m, 2);
                check_frame("burst0", burst[0]);
                for (int j = 1; j < 5; j++) begin
                    @(negedge clock);
                    check_frame($sformatf("burst%0d", j), burst[j]);
                end
            end
        join
        @(negedge clock);
        check("tx idle after burst", tx, 1'b1);
        check("busy after burst", busy, 1'b0);
        lows = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        check("no 6th frame", lows, 0);
        check("ovf sticky", overflow, 1'b1);

        // reset in the middle of data bit 3 with a second byte queued
        do_reset();
        check("ovf cleared by reset", overflow, 1'b0);
        bus = 11'h4FF;
        wait_start(12, n);
        check("latency FF", n, 2);
        repeat (5) @(negedge clock);
        bus = 11'h0FF;
        repeat (12) @(negedge clock);
        check("busy mid frame", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("tx on reset", tx, 1'b1);
        check("busy on reset", busy, 1'b0);
        check("full on reset", fifo_full, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        lows = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        check("no frame after reset", lows, 0);
        check("busy after reset", busy, 1'b0);

`ifdef IO_UART_TX_PARITY_EN
        do_reset();
        bus = 11'h407;
        wait_start(12, n);
        check("latency 07", n, 2);
        check_frame("f07", 8'h07);
        @(negedge clock);
        check("busy after 07", busy, 1'b0);
        bus = 11'h003;
        wait_start(12, n);
        check("latency 03", n, 2);
        check_frame("f03", 8'h03);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
